// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared funct3 codes, FSM encoding, size codes and legality check
// for the RV32I load/store unit.
`default_nettype none

package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b11,
    RESP  = 2'b10
  } state_e;

  // Unsupported funct3 or an access not aligned to its natural size.
  function automatic logic access_fault(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    if (is_store) begin
      bad_f3 = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
    end else begin
      bad_f3 = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W) &&
               (funct3 != F3_BU) && (funct3 != F3_HU);
    end
    misaligned = ((funct3[1:0] == SIZE_HALF) && addr_lo[0]) ||
                 ((funct3[1:0] == SIZE_WORD) && (addr_lo != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: selects the addressed byte/half of a 32-bit word and
// sign- or zero-extends it according to funct3.
`default_nettype none

module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] byte_w;
  logic [31:0] half_w;

  always_comb begin
    byte_w = word_i >> {addr_i, 3'b000};
    half_w = word_i >> {addr_i[1], 4'b0000};
    case (funct3_i)
      F3_B:    data_o = {{24{byte_w[7]}}, byte_w[7:0]};
      F3_H:    data_o = {{16{half_w[15]}}, half_w[15:0]};
      F3_BU:   data_o = {24'd0, byte_w[7:0]};
      F3_HU:   data_o = {16'd0, half_w[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store unit sequencing one request at a time
// onto the datamem RD*/WR* interface and returning a write-back response.
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [XLEN-1:0]       req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  input  logic [REG_ADDR_W-1:0] req_rd_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  resp_we_o,
  output logic [REG_ADDR_W-1:0] resp_rd_o,
  output logic [XLEN-1:0]       resp_data_o,
  output logic                  resp_exc_o,
  output logic                  rden_o,
  output logic [XLEN-1:0]       rdaddr_o,
  output logic [1:0]            rdsize_o,
  output logic                  rdsigned_o,
  input  logic                  rdvalid_i,
  input  logic [XLEN-1:0]       rddata_i,
  output logic                  wren_o,
  output logic [XLEN-1:0]       wraddr_o,
  output logic [3:0]            wrstrb_o,
  output logic [XLEN-1:0]       wrdata_o,
  input  logic                  loading_i
);

  state_e                state_q, state_d;
  logic                  squash_q, squash_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;

  logic                  rden_q, rden_d;
  logic [XLEN-1:0]       rdaddr_q, rdaddr_d;
  logic [1:0]            rdsize_q, rdsize_d;
  logic                  rdsigned_q, rdsigned_d;
  logic                  wren_q, wren_d;
  logic [XLEN-1:0]       wraddr_q, wraddr_d;
  logic [3:0]            wrstrb_q, wrstrb_d;
  logic [XLEN-1:0]       wrdata_q, wrdata_d;

  logic                  resp_we_q, resp_we_d;
  logic [REG_ADDR_W-1:0] resp_rd_q, resp_rd_d;
  logic [XLEN-1:0]       resp_data_q, resp_data_d;
  logic                  resp_exc_q, resp_exc_d;

  logic                  accept_w;
  logic                  fault_w;
  logic                  bus_done_w;
  logic [XLEN-1:0]       ext_data_w;
  logic [XLEN-1:0]       word_addr_w;

  assign accept_w    = req_valid_i && !flush_i;
  assign fault_w     = access_fault(req_store_i, req_funct3_i, req_addr_i[1:0]);
  assign bus_done_w  = ((state_q == LOAD) && rdvalid_i) ||
                       ((state_q == STORE) && !loading_i);
  assign word_addr_w = {req_addr_i[XLEN-1:2], 2'b00};

  load_extend u_load_extend (
    .word_i   (rddata_i),
    .addr_i   (addr_lo_q),
    .funct3_i (funct3_q),
    .data_o   (ext_data_w)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      squash_q    <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      rden_q      <= 1'b0;
      rdaddr_q    <= '0;
      rdsize_q    <= 2'd0;
      rdsigned_q  <= 1'b0;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      wrstrb_q    <= 4'd0;
      wrdata_q    <= '0;
      resp_we_q   <= 1'b0;
      resp_rd_q   <= '0;
      resp_data_q <= '0;
      resp_exc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      squash_q    <= squash_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      rden_q      <= rden_d;
      rdaddr_q    <= rdaddr_d;
      rdsize_q    <= rdsize_d;
      rdsigned_q  <= rdsigned_d;
      wren_q      <= wren_d;
      wraddr_q    <= wraddr_d;
      wrstrb_q    <= wrstrb_d;
      wrdata_q    <= wrdata_d;
      resp_we_q   <= resp_we_d;
      resp_rd_q   <= resp_rd_d;
      resp_data_q <= resp_data_d;
      resp_exc_q  <= resp_exc_d;
    end
  end

  // A squashed transaction still finishes on the bus but skips RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          if (fault_w)          state_d = RESP;
          else if (req_store_i) state_d = STORE;
          else                  state_d = LOAD;
        end
      end
      LOAD, STORE: begin
        if (bus_done_w) state_d = (squash_q || flush_i) ? IDLE : RESP;
      end
      RESP: begin
        if (flush_i || resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    squash_d    = 1'b0;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    rden_d      = rden_q;
    rdaddr_d    = rdaddr_q;
    rdsize_d    = rdsize_q;
    rdsigned_d  = rdsigned_q;
    wren_d      = wren_q;
    wraddr_d    = wraddr_q;
    wrstrb_d    = wrstrb_q;
    wrdata_d    = wrdata_q;
    resp_we_d   = resp_we_q;
    resp_rd_d   = resp_rd_q;
    resp_data_d = resp_data_q;
    resp_exc_d  = resp_exc_q;

    case (state_q)
      IDLE: begin
        if (accept_w) begin
          funct3_d    = req_funct3_i;
          addr_lo_d   = req_addr_i[1:0];
          resp_rd_d   = req_rd_i;
          resp_we_d   = 1'b0;
          resp_data_d = '0;
          resp_exc_d  = fault_w;
          if (!fault_w && !req_store_i) begin
            rden_d     = 1'b1;
            rdaddr_d   = word_addr_w;
            rdsize_d   = req_funct3_i[1:0];
            rdsigned_d = ~req_funct3_i[2];
          end
          if (!fault_w && req_store_i) begin
            wren_d   = 1'b1;
            wraddr_d = word_addr_w;
            case (req_funct3_i[1:0])
              SIZE_BYTE: begin
                wrstrb_d = 4'b0001 << req_addr_i[1:0];
                wrdata_d = {4{req_wdata_i[7:0]}};
              end
              SIZE_HALF: begin
                wrstrb_d = 4'b0011 << req_addr_i[1:0];
                wrdata_d = {2{req_wdata_i[15:0]}};
              end
              default: begin
                wrstrb_d = 4'b1111;
                wrdata_d = req_wdata_i;
              end
            endcase
          end
        end
      end
      LOAD: begin
        squash_d = squash_q || flush_i;
        if (rdvalid_i) begin
          rden_d      = 1'b0;
          resp_data_d = ext_data_w;
          resp_we_d   = 1'b1;
        end
      end
      STORE: begin
        squash_d = squash_q || flush_i;
        if (!loading_i) wren_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
    resp_we_o    = resp_we_q;
    resp_rd_o    = resp_rd_q;
    resp_data_o  = resp_data_q;
    resp_exc_o   = resp_exc_q;
    rden_o       = rden_q;
    rdaddr_o     = rdaddr_q;
    rdsize_o     = rdsize_q;
    rdsigned_o   = rdsigned_q;
    wren_o       = wren_q;
    wraddr_o     = wraddr_q;
    wrstrb_o     = wrstrb_q;
    wrdata_o     = wrdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_exc;
  logic        rden;
  logic [31:0] rdaddr;
  logic [1:0]  rdsize;
  logic        rdsigned;
  logic        rdvalid;
  logic [31:0] rddata;
  logic        wren;
  logic [31:0] wraddr;
  logic [3:0]  wrstrb;
  logic [31:0] wrdata;
  logic        loading;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_rd_i     (req_rd),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_we_o    (resp_we),
    .resp_rd_o    (resp_rd),
    .resp_data_o  (resp_data),
    .resp_exc_o   (resp_exc),
    .rden_o       (rden),
    .rdaddr_o     (rdaddr),
    .rdsize_o     (rdsize),
    .rdsigned_o   (rdsigned),
    .rdvalid_i    (rdvalid),
    .rddata_i     (rddata),
    .wren_o       (wren),
    .wraddr_o     (wraddr),
    .wrstrb_o     (wrstrb),
    .wrdata_o     (wrdata),
    .loading_i    (loading)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one accepting edge, then withdraw it.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  // Load already in LOAD state: return data, check response, retire it.
  task automatic finish_load(input string tag, input logic [31:0] word,
                             input logic [31:0] exp_data, input logic [4:0] rd);
    rdvalid = 1'b1; rddata = word;
    tick();
    rdvalid = 1'b0;
    check({tag, "_rden_low"}, {31'd0, rden}, 32'd0);
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_we"}, {31'd0, resp_we}, 32'd1);
    check({tag, "_rd"}, {27'd0, resp_rd}, {27'd0, rd});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  task automatic exc_case(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
    logic bus_seen;
    bus_seen = 1'b0;
    issue(st, f3, a, 32'h1111_2222, 5'd9);
    for (int i = 0; i < 4 && !resp_valid; i++) begin
      if (rden || wren) bus_seen = 1'b1;
      tick();
    end
    if (rden || wren) bus_seen = 1'b1;
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_no_bus"}, {31'd0, bus_seen}, 32'd0);
    check({tag, "_exc_we_data"}, {30'd0, resp_exc, resp_we}, 32'd2);
    check({tag, "_data"}, resp_data, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = '0; req_wdata = '0; req_rd = '0;
    resp_ready = 1'b0; rdvalid = 1'b0; rddata = '0; loading = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs", {28'd0, resp_valid, rden, wren, resp_exc}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // LB at 0x1003
    issue(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd7);
    check("lb_rden", {31'd0, rden}, 32'd1);
    check("lb_rdaddr", rdaddr, 32'h0000_1000);
    check("lb_size_signed", {29'd0, rdsize, rdsigned}, 32'b001);
    check("lb_ready_low", {31'd0, req_ready}, 32'd0);
    tick();
    check("lb_rden_held", {31'd0, rden}, 32'd1);
    finish_load("lb", 32'h80FF_1234, 32'hFFFF_FF80, 5'd7);

    // LHU / LH at 0x2002
    issue(1'b0, 3'b101, 32'h0000_2002, 32'd0, 5'd3);
    check("lhu_signed", {31'd0, rdsigned}, 32'd0);
    finish_load("lhu", 32'hBEEF_0001, 32'h0000_BEEF, 5'd3);
    issue(1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd4);
    finish_load("lh", 32'hBEEF_0001, 32'hFFFF_BEEF, 5'd4);

    // SB at 0x3001; datamem reports busy in the first store cycle
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 5'd0);
    loading = 1'b1;
    check("sb_wren", {31'd0, wren}, 32'd1);
    check("sb_strb", {28'd0, wrstrb}, 32'b0010);
    check("sb_wrdata", wrdata, 32'hABAB_ABAB);
    check("sb_wraddr", wraddr, 32'h0000_3000);
    check("sb_no_rden", {31'd0, rden}, 32'd0);
    tick();
    check("sb_wren_busy", {31'd0, wren}, 32'd1);
    loading = 1'b0;
    tick();
    check("sb_wren_drop", {31'd0, wren}, 32'd0);
    check("sb_resp", {29'd0, resp_valid, resp_we, resp_exc}, 32'b100);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // SH at 0x3002 strobes/data
    issue(1'b1, 3'b001, 32'h0000_3002, 32'hAAAA_5678, 5'd0);
    loading = 1'b1;
    check("sh_strb", {28'd0, wrstrb}, 32'b1100);
    check("sh_wrdata", wrdata, 32'h5678_5678);
    loading = 1'b0;
    tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Exceptions
    exc_case("lw_mis", 1'b0, 3'b010, 32'h0000_4002);
    exc_case("sh_mis", 1'b1, 3'b001, 32'h0000_4001);
    exc_case("ld_f3", 1'b0, 3'b011, 32'h0000_4000);

    // Flush during LOAD
    issue(1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_rden_held", {31'd0, rden}, 32'd1);
    tick();
    check("fl_rden_held2", {31'd0, rden}, 32'd1);
    rdvalid = 1'b1; rddata = 32'h0BAD_0BAD;
    tick();
    rdvalid = 1'b0;
    check("fl_no_resp", {30'd0, resp_valid, rden}, 32'd0);
    check("fl_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check("fl_stays_idle", {30'd0, resp_valid, req_ready}, 32'd1);

    // Response held under back-pressure
    issue(1'b0, 3'b010, 32'h0000_6000, 32'd0, 5'd11);
    rdvalid = 1'b1; rddata = 32'hCAFE_F00D;
    tick();
    rdvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_data", resp_data, 32'hCAFE_F00D);
      tick();
    end
    // Flush wins over ready in RESP
    flush = 1'b1; resp_ready = 1'b1;
    tick();
    flush = 1'b0; resp_ready = 1'b0;
    check("resp_flush", {30'd0, resp_valid, req_ready}, 32'd1);

    // Asynchronous reset in LOAD
    issue(1'b0, 3'b010, 32'h0000_7000, 32'd0, 5'd12);
    check("rst_pre_rden", {31'd0, rden}, 32'd1);
    rstn = 1'b0;
    #1;
    check("arst_outs", {28'd0, resp_valid, rden, wren, resp_exc}, 32'd0);
    check("arst_rdaddr", rdaddr, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
